// File: rtl/conv1_frame_ctrl_if.sv
// Bus between the conv1 frame sequencer and its environment
// (start control, image memory read port, conv layer hooks, status).
interface conv1_frame_ctrl_if #(
    parameter int unsigned AW = 10
);
    logic          start;
    logic          img_rd_en;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_data;
    logic [7:0]    pix_out;
    logic          conv_rst_n;
    logic          conv_valid;
    logic [AW-1:0] out_cnt;
    logic          busy;
    logic          frame_done;
    logic          err;

    // Sequencer side
    modport master (
        input  start, img_data, conv_valid,
        output img_rd_en, img_addr, pix_out, conv_rst_n, out_cnt, busy, frame_done, err
    );

    // Environment side (top-level control, image store, conv layer)
    modport slave (
        output start, img_data, conv_valid,
        input  img_rd_en, img_addr, pix_out, conv_rst_n, out_cnt, busy, frame_done, err
    );
endinterface

// File: rtl/conv1_frame_ctrl.sv
// Frame sequencer for conv layer 1: clears the line buffer, streams one image
// from a synchronous memory in raster order, counts layer outputs and reports
// completion or a drain timeout.
module conv1_frame_ctrl #(
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28,
    parameter int unsigned K          = 5,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned DRAIN_MAX  = 64,
    parameter int unsigned AW         = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    conv1_frame_ctrl_if.master  bus
);
    localparam int unsigned N_PIX = IMG_W * IMG_H;
    localparam int unsigned N_OUT = (IMG_W - K + 1) * (IMG_H - K + 1);
    localparam int unsigned DW    = $clog2(DRAIN_MAX + 1);
    localparam int unsigned CW    = $clog2(CLR_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] clr_cnt;
    logic [DW-1:0] drain_cnt;
    logic          rd_d;
    logic          cnt_full;

    assign cnt_full = (bus.out_cnt == AW'(N_OUT));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; STREAM ends when the last pixel lands in pix_out,
    // which is the only cycle where the read pipe is full but reads stopped
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.start) state_next = S_CLEAR;
            S_CLEAR:  if (clr_cnt == CW'(CLR_CYCLES - 1)) state_next = S_STREAM;
            S_STREAM: if (rd_d && !bus.img_rd_en) state_next = S_DRAIN;
            S_DRAIN:  if (cnt_full || drain_cnt == DW'(DRAIN_MAX - 1)) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Registered outputs, read pipeline and frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.img_rd_en  <= 1'b0;
            bus.img_addr   <= '0;
            bus.pix_out    <= 8'd0;
            bus.conv_rst_n <= 1'b1;
            bus.out_cnt    <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
            clr_cnt        <= '0;
            drain_cnt      <= '0;
            rd_d           <= 1'b0;
        end else begin
            bus.busy       <= (state_next != S_IDLE);
            bus.frame_done <= (state_next == S_DONE);
            bus.conv_rst_n <= (state_next != S_CLEAR);

            rd_d        <= bus.img_rd_en;
            bus.pix_out <= rd_d ? bus.img_data : 8'd0;

            clr_cnt   <= (state == S_CLEAR) ? clr_cnt + CW'(1) : '0;
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;

            // Address generator: contiguous raster sweep, one address per cycle
            if (state == S_CLEAR && state_next == S_STREAM) begin
                bus.img_rd_en <= 1'b1;
                bus.img_addr  <= '0;
            end else if (bus.img_rd_en) begin
                if (bus.img_addr == AW'(N_PIX - 1)) bus.img_rd_en <= 1'b0;
                else                                bus.img_addr  <= bus.img_addr + AW'(1);
            end

            // Output counter saturates at the expected output count
            if (state == S_IDLE && bus.start) begin
                bus.out_cnt <= '0;
                bus.err     <= 1'b0;
            end else if ((state == S_STREAM || state == S_DRAIN) && bus.conv_valid && !cnt_full) begin
                bus.out_cnt <= bus.out_cnt + AW'(1);
            end

            // Leaving DRAIN short of the full count means the layer stalled
            if (state == S_DRAIN && state_next == S_DONE && !cnt_full) bus.err <= 1'b1;
        end
    end
endmodule
